// File: rtl/fifo_read_ctrl.sv
// Read-side controller for an asynchronous FIFO, clocked by the read clock.
// It pops words from the FIFO and absorbs the FIFO's one-cycle read latency in a small skid buffer.
// Buffered words are presented downstream as a valid/ready stream.
// It also counts the words delivered downstream and keeps a sticky underflow flag.
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  RCLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  EMPTY,
    output logic                  READ_ENABLE,
    input  logic [DATA_WIDTH-1:0] READ_DATA,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  WORD_COUNT,
    output logic                  UNDERFLOW
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    // Wide enough to hold occupancy plus one in-flight word.
    localparam int OCC_W = $clog2(SKID_DEPTH + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] buf_d [SKID_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  in_flight_q, in_flight_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  underflow_q, underflow_d;

    logic                  pop_out;
    logic                  capture;
    logic [OCC_W-1:0]      pending;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign OUT_VALID  = (occ_q != '0);
    assign OUT_DATA   = OUT_VALID ? buf_q[head_q] : '0;
    assign BUSY       = (state_q != IDLE);
    assign WORD_COUNT = count_q;
    assign UNDERFLOW  = underflow_q;

    // Next-state logic for the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ENABLE) state_d = RUN;
            RUN:     if (!ENABLE) state_d = DRAIN;
            DRAIN: begin
                if (ENABLE) begin
                    state_d = RUN;
                end else if (!in_flight_q && (occ_q == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit-based pop decision plus the next-state values for the skid buffer, counter and flags.
    // A word leaving this cycle frees a slot, so a pop may be issued against a full buffer.
    always_comb begin
        pop_out     = OUT_VALID && OUT_READY;
        capture     = in_flight_q;
        pending     = occ_q + OCC_W'(in_flight_q) - OCC_W'(pop_out);
        READ_ENABLE = (state_q == RUN) && !EMPTY && (pending < OCC_W'(SKID_DEPTH));

        buf_d  = buf_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (capture) begin
            buf_d[tail_q] = READ_DATA;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop_out) begin
            head_d = ptr_inc(head_q);
        end
        case ({capture, pop_out})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        in_flight_d = READ_ENABLE;
        count_d     = pop_out ? (count_q + CNT_WIDTH'(1)) : count_q;
        underflow_d = underflow_q | (READ_ENABLE & EMPTY);
    end

    // State register; reset drops any buffered or in-flight words.
    always_ff @(posedge RCLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            in_flight_q <= 1'b0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule
